// File: rtl/fp32_mul_pipe.sv
// fp32_mul_pipe: 3-stage pipelined IEEE-754 single-precision multiplier.
//   Round-to-nearest-even, flush-to-zero on inputs and outputs, canonical
//   quiet NaN (QNAN) for every NaN/invalid result.
//   Stages: S1 unpack/classify, S2 24x24 multiply, S3 normalise/round/pack
//   (S3 is the output register).
// Ports:
//   CLK, RST            clock (rising edge), synchronous active-high reset
//   IN_VALID/IN_READY   operand handshake, IN_A/IN_B operands
//   OUT_VALID/OUT_READY product handshake, OUT_DATA product
//   OUT_FLAGS           {NV,OF,UF,NX}, only when FPU_MUL_FLAGS_EN is defined
// Optional feature macro: FPU_MUL_FLAGS_EN
module fp32_mul_pipe #(
  parameter logic [31:0] QNAN = 32'h7FC00000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] IN_A,
  input  logic [31:0] IN_B,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] OUT_DATA
`ifdef FPU_MUL_FLAGS_EN
  ,
  output logic [3:0]  OUT_FLAGS
`endif
);

  typedef enum logic [2:0] {
    CLS_NORM,
    CLS_QNAN,
    CLS_INVALID,
    CLS_INF,
    CLS_ZERO
  } cls_t;

  logic en;

  // S1 registers
  logic              s1_valid;
  logic              s1_sign;
  logic signed [9:0] s1_esum;
  logic [23:0]       s1_ma, s1_mb;
  cls_t              s1_cls;

  // S2 registers
  logic              s2_valid;
  logic              s2_sign;
  logic signed [9:0] s2_esum;
  logic [47:0]       s2_p;
  cls_t              s2_cls;

  // S1 combinational unpack
  logic [7:0]        ea, eb;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  cls_t              cls_in;
  logic signed [9:0] esum_in;

  // S3 combinational normalise/round/pack
  logic [22:0]       mant, mant_fin;
  logic [23:0]       mant_inc;
  logic              guard, sticky, round_up;
  logic signed [9:0] e_norm, e_fin;
  logic [31:0]       res_data;
`ifdef FPU_MUL_FLAGS_EN
  logic [3:0]        res_flags;
`endif

  assign en       = ~OUT_VALID | OUT_READY;
  assign IN_READY = en;

  always_comb begin
    ea      = IN_A[30:23];
    eb      = IN_B[30:23];
    a_nan   = (&ea) & (|IN_A[22:0]);
    b_nan   = (&eb) & (|IN_B[22:0]);
    a_inf   = (&ea) & ~(|IN_A[22:0]);
    b_inf   = (&eb) & ~(|IN_B[22:0]);
    // exp==0 covers both true zero and denormals (flushed to zero)
    a_zero  = (ea == 8'h00);
    b_zero  = (eb == 8'h00);
    esum_in = {2'b00, ea} + {2'b00, eb} - 10'd127;
    if (a_nan | b_nan)
      cls_in = CLS_QNAN;
    else if ((a_inf & b_zero) | (b_inf & a_zero))
      cls_in = CLS_INVALID;
    else if (a_inf | b_inf)
      cls_in = CLS_INF;
    else if (a_zero | b_zero)
      cls_in = CLS_ZERO;
    else
      cls_in = CLS_NORM;
  end

  always_comb begin
    if (s2_p[47]) begin
      mant   = s2_p[46:24];
      guard  = s2_p[23];
      sticky = |s2_p[22:0];
      e_norm = s2_esum + 10'sd1;
    end else begin
      mant   = s2_p[45:23];
      guard  = s2_p[22];
      sticky = |s2_p[21:0];
      e_norm = s2_esum;
    end
    round_up = guard & (sticky | mant[0]);
    mant_inc = {1'b0, mant} + 24'd1;
    mant_fin = mant;
    e_fin    = e_norm;
    if (round_up) begin
      if (mant_inc[23]) begin
        mant_fin = '0;
        e_fin    = e_norm + 10'sd1;
      end else begin
        mant_fin = mant_inc[22:0];
      end
    end

    res_data = {s2_sign, e_fin[7:0], mant_fin};
`ifdef FPU_MUL_FLAGS_EN
    res_flags = {3'b000, guard | sticky};
`endif
    if (e_fin >= 10'sd255) begin
      res_data = {s2_sign, 8'hFF, 23'h0};
`ifdef FPU_MUL_FLAGS_EN
      res_flags = 4'b0101;
`endif
    end else if (e_fin <= 10'sd0) begin
      res_data = {s2_sign, 31'h0};
`ifdef FPU_MUL_FLAGS_EN
      res_flags = 4'b0011;
`endif
    end

    // Special classes override the arithmetic result
    case (s2_cls)
      CLS_QNAN: begin
        res_data = QNAN;
`ifdef FPU_MUL_FLAGS_EN
        res_flags = 4'b0000;
`endif
      end
      CLS_INVALID: begin
        res_data = QNAN;
`ifdef FPU_MUL_FLAGS_EN
        res_flags = 4'b1000;
`endif
      end
      CLS_INF: begin
        res_data = {s2_sign, 8'hFF, 23'h0};
`ifdef FPU_MUL_FLAGS_EN
        res_flags = 4'b0000;
`endif
      end
      CLS_ZERO: begin
        res_data = {s2_sign, 31'h0};
`ifdef FPU_MUL_FLAGS_EN
        res_flags = 4'b0000;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_esum   <= '0;
      s1_ma     <= '0;
      s1_mb     <= '0;
      s1_cls    <= CLS_NORM;
      s2_valid  <= 1'b0;
      s2_sign   <= 1'b0;
      s2_esum   <= '0;
      s2_p      <= '0;
      s2_cls    <= CLS_NORM;
      OUT_VALID <= 1'b0;
      OUT_DATA  <= '0;
`ifdef FPU_MUL_FLAGS_EN
      OUT_FLAGS <= '0;
`endif
    end else if (en) begin
      s1_valid  <= IN_VALID;
      s1_sign   <= IN_A[31] ^ IN_B[31];
      s1_esum   <= esum_in;
      s1_ma     <= {1'b1, IN_A[22:0]};
      s1_mb     <= {1'b1, IN_B[22:0]};
      s1_cls    <= cls_in;
      s2_valid  <= s1_valid;
      s2_sign   <= s1_sign;
      s2_esum   <= s1_esum;
      s2_p      <= s1_ma * s1_mb;
      s2_cls    <= s1_cls;
      OUT_VALID <= s2_valid;
      OUT_DATA  <= res_data;
`ifdef FPU_MUL_FLAGS_EN
      OUT_FLAGS <= res_flags;
`endif
    end
  end

endmodule

// File: tb/tb_fp32_mul_pipe.sv
// tb_fp32_mul_pipe: directed-vector self-checking bench for fp32_mul_pipe.
module tb_fp32_mul_pipe;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] IN_A, IN_B;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_DATA;
`ifdef FPU_MUL_FLAGS_EN
  logic [3:0]  OUT_FLAGS;
`endif

  int unsigned checks   = 0;
  int unsigned failures = 0;

  fp32_mul_pipe #(.QNAN(32'h7FC00000)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_A      (IN_A),
    .IN_B      (IN_B),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_DATA  (OUT_DATA)
`ifdef FPU_MUL_FLAGS_EN
    ,
    .OUT_FLAGS (OUT_FLAGS)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic [3:0]  f;   // {NV,OF,UF,NX}
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Issue one operand pair into an idle pipe and check latency and result.
  task automatic run_vec(input string tag, input vec_t v);
    int unsigned n;
    IN_A      = v.a;
    IN_B      = v.b;
    IN_VALID  = 1'b1;
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    n = 1;
    while (!OUT_VALID && n < 10) begin
      @(posedge CLK); #1;
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'd3);
    check({tag, "_data"}, OUT_DATA, v.d);
`ifdef FPU_MUL_FLAGS_EN
    check({tag, "_flags"}, 32'(OUT_FLAGS), 32'(v.f));
`endif
  endtask

  initial begin
    int unsigned sent, recv, cyc;
    logic in_acc, out_acc;
    logic [31:0] exp_q[8];

    vecs[0]  = '{32'h3F800000, 32'h40000000, 32'h40000000, 4'b0000};
    vecs[1]  = '{32'hBF800000, 32'h3F800000, 32'hBF800000, 4'b0000};
    vecs[2]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000};
    vecs[3]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000};
    vecs[4]  = '{32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101};
    vecs[5]  = '{32'h00800000, 32'h00800000, 32'h00000000, 4'b0011};
    vecs[6]  = '{32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000};
    vecs[7]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001};
    vecs[8]  = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'b0001};
    vecs[9]  = '{32'h3FC00001, 32'h3FC00001, 32'h40100002, 4'b0001};
    vecs[10] = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001};
    vecs[11] = '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001};
    vecs[12] = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000};
    vecs[13] = '{32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000};

    RST       = 1'b1;
    IN_VALID  = 1'b0;
    IN_A      = '0;
    IN_B      = '0;
    OUT_READY = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_out_valid", 32'(OUT_VALID), 32'd0);
    check("rst_out_data", OUT_DATA, 32'h0);
    check("rst_in_ready", 32'(IN_READY), 32'd1);
`ifdef FPU_MUL_FLAGS_EN
    check("rst_out_flags", 32'(OUT_FLAGS), 32'd0);
`endif
    RST = 1'b0;

    for (int i = 0; i < 14; i++)
      run_vec($sformatf("vec%0d", i), vecs[i]);

    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    repeat (4) @(posedge CLK);
    #1;

    // 8 back-to-back ops: 2^k x 3.0 = 3*2^k, OUT_READY toggling 1,0,1,0...
    for (int k = 0; k < 8; k++)
      exp_q[k] = 32'h40400000 + (32'(k) << 23);
    sent = 0;
    recv = 0;
    cyc  = 0;
    while (recv < 8 && cyc < 60) begin
      IN_VALID  = (sent < 8);
      IN_A      = 32'h3F800000 + (32'(sent) << 23);
      IN_B      = 32'h40400000;
      OUT_READY = (cyc % 2 == 0);
      #1;
      check($sformatf("b2b_in_ready_c%0d", cyc), 32'(IN_READY),
            32'(!(OUT_VALID && !OUT_READY)));
      in_acc  = IN_VALID && IN_READY;
      out_acc = OUT_VALID && OUT_READY;
      if (out_acc) begin
        check($sformatf("b2b_data%0d", recv), OUT_DATA, exp_q[recv]);
        recv++;
      end
      @(posedge CLK); #1;
      if (in_acc) sent++;
      cyc++;
    end
    check("b2b_recv_count", 32'(recv), 32'd8);
    check("b2b_sent_count", 32'(sent), 32'd8);

    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    repeat (4) @(posedge CLK);
    #1;

    // Three ops in flight, then a one-cycle reset flushes all of them
    for (int k = 0; k < 3; k++) begin
      IN_A     = 32'h40000000;
      IN_B     = 32'h40000000;
      IN_VALID = 1'b1;
      @(posedge CLK); #1;
    end
    IN_VALID = 1'b0;
    RST      = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check("flush_valid0", 32'(OUT_VALID), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      @(posedge CLK); #1;
      check($sformatf("flush_valid%0d", k), 32'(OUT_VALID), 32'd0);
    end
    run_vec("post_rst", vecs[0]);

    IN_VALID = 1'b0;
    repeat (2) @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
